nasti_burst_copier: RTL and testbench
=====================================

// Module: nasti_burst_copier
// PURPOSE
// - NASTI (AXI4) DMA copy engine: copies r_len bytes from r_src on the source read port to r_dest on the dest write port.
// - Store-and-forward, one burst at a time, through an internal beat buffer.
// - Sits between a command source (e.g. instruction fetch) and BRAM controllers / memory masters.
// PARAMETERS
// ADDR_WIDTH        64  address width of r_src/r_dest/r_len and AR/AW addr
// DATA_WIDTH        64  R/W data width; beat = DATA_WIDTH/8 bytes (BPB)
// MAX_BURST_LENGTH  8   max beats per burst (1..256); also buffer depth
// PORTS
// aclk         in   1    clock; all logic on rising edge
// rst          in   1    synchronous, active-high reset
// r_src        in   AW   source byte address, BPB-aligned
// r_dest       in   AW   dest byte address, BPB-aligned
// r_len        in   AW   length in bytes, multiple of BPB
// r_valid      in   1    request valid
// r_ready      out  1    request accepted when r_valid&r_ready
// done         out  1    one-cycle pulse at end of request
// err          out  1    sticky: non-OKAY RRESP/BRESP seen in current request
// perf_beats   out  32   total beats written (optional feature)
// src_ar_addr/len[7:0]/size[2:0]/burst[1:0]/valid  out; src_ar_ready  in
// src_r_data[DW]/resp[1:0]/last/valid  in; src_r_ready  out
// dst_aw_addr/len/size/burst/valid  out; dst_aw_ready  in
// dst_w_data[DW]/strb[DW/8]/last/valid  out; dst_w_ready  in
// dst_b_resp[1:0]/valid  in; dst_b_ready  out
// BEHAVIOUR
// - Reset: state IDLE, r_ready=1, done=0, err=0, all *_valid=0, src_r_ready=0, dst_b_ready=0, counters 0.
// - Request accept (IDLE, r_valid&r_ready): latch src, dest, beats=r_len/BPB; clear err.
//   r_ready=0 from the next cycle until the request completes.
// - States: IDLE -> RD_ADDR -> RD_DATA -> WR_ADDR -> WR_DATA -> WR_RESP.
//   - WR_RESP -> RD_ADDR if beats remain, else -> IDLE.
//   - done=1 for one cycle on entry to IDLE from WR_RESP.
// - Zero length: on accept, go straight to IDLE with done pulse on the next cycle; no bus traffic.
// - Burst size n = min(remaining, MAX_BURST_LENGTH). AR/AW fields: len=n-1, size=log2(BPB), burst=INCR(01).
// - RD_ADDR: ar_valid held with stable fields until ar_ready.
// - RD_DATA: src_r_ready=1; each R handshake stores a beat in the buffer.
//   - Leave after the n-th beat.
//   - r_last is not used for counting; a mismatch is not flagged.
// - WR_ADDR: aw_valid held until aw_ready.
//   - Address/len/size/burst are never issued before the buffer holds n beats.
// - WR_DATA: stream buffer beats in order; strb all ones; w_last on beat n; w_valid never drops mid-burst.
// - WR_RESP: b_ready=1; on b_valid, src += n*BPB, dest += n*BPB, remaining -= n.
// - err: set on any RRESP or BRESP != 00. The transfer still runs to completion.
// - Bursts are not split at 4 KiB boundaries; the issuer guarantees this.
// - Inputs r_src/r_dest/r_len are ignored while not in IDLE.
// - rst asserted mid-transfer: abort immediately to reset state; outstanding bus transactions are abandoned.
// CONFIGURATION
// - MOVER_PERF_CNT_EN defined:
//   - perf_beats increments on every W handshake.
//   - Wraps at 2^32; cleared only by rst.
// - Not defined: perf_beats tied to 0, no counter logic.
// TESTING
// 1. DW=64,MBL=8: src=0,dst=0x40,len=64 -> one AR(addr 0,len 7,size 3); 8 R beats;
//    one AW(0x40,len 7); 8 W, last on 8th; done pulse; err=0.
// 2. DW=32,MBL=1: src=0,dst=0,len=8 -> two AR/AW pairs at 0 and 4, len=0 each, w_last on every beat; done after 2nd B.
// 3. len=0 -> no AR/AW; done pulses the cycle after accept; r_ready high again.
// 4. Random ready backpressure on ar/r/aw/w, len=160 DW=64 MBL=8 -> bursts of 8,8,4 beats;
//    data at dest equals src; valids never drop early.
// 5. BRESP=10 on 1st of 2 bursts -> err=1 through completion; 2nd burst still written; err clears on next accept.
// 6. rst during WR_DATA -> next cycle all valids 0, r_ready=1, err=0; new request runs normally.

Source files
------------

// File: rtl/nasti_burst_copier.sv
// nasti_burst_copier: store-and-forward NASTI (AXI4) DMA copy engine.
// Copies r_len bytes from r_src (source read port) to r_dest (dest write
// port). It moves one burst at a time through an internal beat buffer.
// Optional feature macro: MOVER_PERF_CNT_EN adds a 32-bit count of W beats
// (perf_beats). When the macro is undefined, perf_beats is tied to zero.
module nasti_burst_copier #(
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 64,
  parameter int MAX_BURST_LENGTH = 8
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   r_src,
  input  logic [ADDR_WIDTH-1:0]   r_dest,
  input  logic [ADDR_WIDTH-1:0]   r_len,
  input  logic                    r_valid,
  output logic                    r_ready,
  output logic                    done,
  output logic                    err,
  output logic [31:0]             perf_beats,
  output logic [ADDR_WIDTH-1:0]   src_ar_addr,
  output logic [7:0]              src_ar_len,
  output logic [2:0]              src_ar_size,
  output logic [1:0]              src_ar_burst,
  output logic                    src_ar_valid,
  input  logic                    src_ar_ready,
  input  logic [DATA_WIDTH-1:0]   src_r_data,
  input  logic [1:0]              src_r_resp,
  input  logic                    src_r_last,
  input  logic                    src_r_valid,
  output logic                    src_r_ready,
  output logic [ADDR_WIDTH-1:0]   dst_aw_addr,
  output logic [7:0]              dst_aw_len,
  output logic [2:0]              dst_aw_size,
  output logic [1:0]              dst_aw_burst,
  output logic                    dst_aw_valid,
  input  logic                    dst_aw_ready,
  output logic [DATA_WIDTH-1:0]   dst_w_data,
  output logic [DATA_WIDTH/8-1:0] dst_w_strb,
  output logic                    dst_w_last,
  output logic                    dst_w_valid,
  input  logic                    dst_w_ready,
  input  logic [1:0]              dst_b_resp,
  input  logic                    dst_b_valid,
  output logic                    dst_b_ready
);

  localparam int BPB   = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BPB);
  localparam int IW    = (MAX_BURST_LENGTH > 1) ? $clog2(MAX_BURST_LENGTH) : 1;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic [ADDR_WIDTH-1:0]   dst_addr;
  logic [ADDR_WIDTH-1:0]   remaining;
  logic [8:0]              burst_n;
  logic [7:0]              burst_len;
  logic [8:0]              cnt;
  logic [DATA_WIDTH-1:0]   beat_buf [DEPTH];

  logic [ADDR_WIDTH-1:0]   req_beats;
  logic [ADDR_WIDTH-1:0]   next_rem;
  logic [ADDR_WIDTH-1:0]   burst_bytes;
  logic [8:0]              cnt_plus;
  logic                    unused_ok;

  // Beats in the next burst: the smaller of the beats left and the buffer depth.
  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] rem);
    if (rem > ADDR_WIDTH'(MAX_BURST_LENGTH)) burst_beats = 9'(MAX_BURST_LENGTH);
    else                                     burst_beats = rem[8:0];
  endfunction

  assign req_beats    = r_len >> SIZE;
  assign next_rem     = remaining - ADDR_WIDTH'(burst_n);
  assign burst_bytes  = ADDR_WIDTH'(burst_n) << SIZE;
  assign cnt_plus     = cnt + 9'd1;

  assign src_ar_addr  = src_addr;
  assign src_ar_len   = burst_len;
  assign src_ar_size  = 3'(SIZE);
  assign src_ar_burst = 2'b01;
  assign dst_aw_addr  = dst_addr;
  assign dst_aw_len   = burst_len;
  assign dst_aw_size  = 3'(SIZE);
  assign dst_aw_burst = 2'b01;
  assign dst_w_strb   = '1;

  // r_last is deliberately ignored; the beat count alone ends a read burst.
  assign unused_ok    = src_r_last;

  // Capture each accepted read beat into the buffer slot given by the beat index.
  always_ff @(posedge aclk) begin
    if (state == RD_DATA && src_r_valid && src_r_ready) begin
      beat_buf[cnt[IW-1:0]] <= src_r_data;
    end
  end

  // Copy-engine FSM: accept a request, then read a burst, write it, and await B.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state        <= IDLE;
      r_ready      <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      src_addr     <= '0;
      dst_addr     <= '0;
      remaining    <= '0;
      burst_n      <= 9'd0;
      burst_len    <= 8'd0;
      cnt          <= 9'd0;
      src_ar_valid <= 1'b0;
      src_r_ready  <= 1'b0;
      dst_aw_valid <= 1'b0;
      dst_w_valid  <= 1'b0;
      dst_w_last   <= 1'b0;
      dst_w_data   <= '0;
      dst_b_ready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (r_valid && r_ready) begin
            src_addr <= r_src;
            dst_addr <= r_dest;
            err      <= 1'b0;
            if (req_beats == '0) begin
              done <= 1'b1;
            end else begin
              remaining    <= req_beats;
              burst_n      <= burst_beats(req_beats);
              burst_len    <= 8'(burst_beats(req_beats) - 9'd1);
              r_ready      <= 1'b0;
              src_ar_valid <= 1'b1;
              state        <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (src_ar_ready) begin
            src_ar_valid <= 1'b0;
            src_r_ready  <= 1'b1;
            cnt          <= 9'd0;
            state        <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (src_r_valid) begin
            if (src_r_resp != 2'b00) err <= 1'b1;
            if (cnt == burst_n - 9'd1) begin
              src_r_ready  <= 1'b0;
              dst_aw_valid <= 1'b1;
              cnt          <= 9'd0;
              state        <= WR_ADDR;
            end else begin
              cnt <= cnt_plus;
            end
          end
        end
        WR_ADDR: begin
          if (dst_aw_ready) begin
            dst_aw_valid <= 1'b0;
            dst_w_valid  <= 1'b1;
            dst_w_data   <= beat_buf[0];
            dst_w_last   <= (burst_n == 9'd1);
            cnt          <= 9'd0;
            state        <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (dst_w_ready) begin
            if (cnt == burst_n - 9'd1) begin
              dst_w_valid <= 1'b0;
              dst_w_last  <= 1'b0;
              dst_b_ready <= 1'b1;
              state       <= WR_RESP;
            end else begin
              cnt        <= cnt_plus;
              dst_w_data <= beat_buf[cnt_plus[IW-1:0]];
              dst_w_last <= (cnt_plus + 9'd1 == burst_n);
            end
          end
        end
        WR_RESP: begin
          if (dst_b_valid) begin
            if (dst_b_resp != 2'b00) err <= 1'b1;
            dst_b_ready <= 1'b0;
            src_addr    <= src_addr + burst_bytes;
            dst_addr    <= dst_addr + burst_bytes;
            remaining   <= next_rem;
            if (next_rem == '0) begin
              r_ready <= 1'b1;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              burst_n      <= burst_beats(next_rem);
              burst_len    <= 8'(burst_beats(next_rem) - 9'd1);
              src_ar_valid <= 1'b1;
              state        <= RD_ADDR;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MOVER_PERF_CNT_EN
  // Free-running count of written beats; wraps at 2^32 and clears only on reset.
  always_ff @(posedge aclk) begin
    if (rst) begin
      perf_beats <= 32'd0;
    end else if (dst_w_valid && dst_w_ready) begin
      perf_beats <= perf_beats + 32'd1;
    end
  end
`else
  assign perf_beats = 32'd0;
`endif

endmodule

// File: tb/tb_nasti_burst_copier.sv
// Directed bench for nasti_burst_copier (64-bit data, 8-beat bursts) with a
// behavioural source/dest memory slave and hand-computed expectations.
`timescale 1ns/1ps
module tb_nasti_burst_copier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] r_src = 64'd0, r_dest = 64'd0, r_len = 64'd0;
  logic        r_valid = 1'b0;
  logic        r_ready, done, err;
  logic [31:0] perf_beats;
  logic [63:0] src_ar_addr;
  logic [7:0]  src_ar_len;
  logic [2:0]  src_ar_size;
  logic [1:0]  src_ar_burst;
  logic        src_ar_valid, src_ar_ready;
  logic [63:0] src_r_data;
  logic [1:0]  src_r_resp;
  logic        src_r_last, src_r_valid, src_r_ready;
  logic [63:0] dst_aw_addr;
  logic [7:0]  dst_aw_len;
  logic [2:0]  dst_aw_size;
  logic [1:0]  dst_aw_burst;
  logic        dst_aw_valid, dst_aw_ready;
  logic [63:0] dst_w_data;
  logic [7:0]  dst_w_strb;
  logic        dst_w_last, dst_w_valid, dst_w_ready;
  logic [1:0]  dst_b_resp;
  logic        dst_b_valid, dst_b_ready;

  always #5 clk = ~clk;

  nasti_burst_copier dut (
    .aclk(clk), .rst(rst),
    .r_src(r_src), .r_dest(r_dest), .r_len(r_len), .r_valid(r_valid),
    .r_ready(r_ready), .done(done), .err(err), .perf_beats(perf_beats),
    .src_ar_addr(src_ar_addr), .src_ar_len(src_ar_len), .src_ar_size(src_ar_size),
    .src_ar_burst(src_ar_burst), .src_ar_valid(src_ar_valid), .src_ar_ready(src_ar_ready),
    .src_r_data(src_r_data), .src_r_resp(src_r_resp), .src_r_last(src_r_last),
    .src_r_valid(src_r_valid), .src_r_ready(src_r_ready),
    .dst_aw_addr(dst_aw_addr), .dst_aw_len(dst_aw_len), .dst_aw_size(dst_aw_size),
    .dst_aw_burst(dst_aw_burst), .dst_aw_valid(dst_aw_valid), .dst_aw_ready(dst_aw_ready),
    .dst_w_data(dst_w_data), .dst_w_strb(dst_w_strb), .dst_w_last(dst_w_last),
    .dst_w_valid(dst_w_valid), .dst_w_ready(dst_w_ready),
    .dst_b_resp(dst_b_resp), .dst_b_valid(dst_b_valid), .dst_b_ready(dst_b_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Memory images and slave controls
  logic [63:0] src_mem [64];
  logic [63:0] dst_mem [64];
  bit          bp = 1'b0;
  bit          w_stall = 1'b0;
  int          b_err_idx = -1;

  // Slave bookkeeping
  logic [63:0] rd_addr_q[$];
  logic [7:0]  rd_len_q[$];
  logic [63:0] wr_addr_q[$];
  logic [7:0]  wr_len_q[$];
  int r_beat, w_beat, b_pend, b_idx;
  bit ar_pend, aw_pend, w_pend;

  // Logs
  logic [63:0] ar_log [8];
  logic [7:0]  arlen_log [8];
  logic [63:0] aw_log [8];
  logic [7:0]  awlen_log [8];
  int ar_n, aw_n, proto_bad, drop_bad, w_total, done_cnt;

  task automatic clear_logs();
    for (int i = 0; i < 64; i++) dst_mem[i] = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int i = 0; i < 8; i++) begin
      ar_log[i] = '0; arlen_log[i] = '0; aw_log[i] = '0; awlen_log[i] = '0;
    end
    ar_n = 0; aw_n = 0; proto_bad = 0; drop_bad = 0; done_cnt = 0; b_idx = 0;
  endtask

  function automatic int mism(input int d0, input int s0, input int n);
    int m = 0;
    for (int i = 0; i < n; i++) if (dst_mem[d0 + i] !== src_mem[s0 + i]) m++;
    return m;
  endfunction

  // Memory slave: samples handshakes at posedge, drives responses at negedge
  initial begin
    src_ar_ready = 1'b0; src_r_valid = 1'b0; src_r_data = '0; src_r_resp = 2'b00;
    src_r_last = 1'b0; dst_aw_ready = 1'b0; dst_w_ready = 1'b0;
    dst_b_valid = 1'b0; dst_b_resp = 2'b00;
    r_beat = 0; w_beat = 0; b_pend = 0; w_total = 0;
    ar_pend = 0; aw_pend = 0; w_pend = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        rd_addr_q.delete(); rd_len_q.delete(); wr_addr_q.delete(); wr_len_q.delete();
        r_beat = 0; w_beat = 0; b_pend = 0; w_total = 0;
        ar_pend = 0; aw_pend = 0; w_pend = 0;
      end else begin
        if (ar_pend && !src_ar_valid) drop_bad++;
        if (aw_pend && !dst_aw_valid) drop_bad++;
        if (w_pend && !dst_w_valid) drop_bad++;
        ar_pend = src_ar_valid && !src_ar_ready;
        aw_pend = dst_aw_valid && !dst_aw_ready;
        w_pend  = dst_w_valid && !dst_w_ready;
        if (done) done_cnt++;
        if (src_ar_valid && src_ar_ready) begin
          rd_addr_q.push_back(src_ar_addr); rd_len_q.push_back(src_ar_len);
          if (ar_n < 8) begin ar_log[ar_n] = src_ar_addr; arlen_log[ar_n] = src_ar_len; end
          ar_n++;
          if (src_ar_size != 3'd3 || src_ar_burst != 2'b01) proto_bad++;
        end
        if (src_r_valid && src_r_ready && rd_len_q.size() > 0) begin
          if (r_beat == int'(rd_len_q[0])) begin
            void'(rd_addr_q.pop_front()); void'(rd_len_q.pop_front()); r_beat = 0;
          end else r_beat++;
        end
        if (dst_aw_valid && dst_aw_ready) begin
          if (rd_addr_q.size() > 0) proto_bad++;
          wr_addr_q.push_back(dst_aw_addr); wr_len_q.push_back(dst_aw_len);
          if (aw_n < 8) begin aw_log[aw_n] = dst_aw_addr; awlen_log[aw_n] = dst_aw_len; end
          aw_n++;
          if (dst_aw_size != 3'd3 || dst_aw_burst != 2'b01) proto_bad++;
        end
        if (dst_w_valid && dst_w_ready) begin
          w_total++;
          if (wr_addr_q.size() == 0) proto_bad++;
          else begin
            dst_mem[(int'(wr_addr_q[0] >> 3) + w_beat) & 63] = dst_w_data;
            if (dst_w_last != (w_beat == int'(wr_len_q[0]))) proto_bad++;
            if (dst_w_strb != 8'hFF) proto_bad++;
            if (w_beat == int'(wr_len_q[0])) begin
              void'(wr_addr_q.pop_front()); void'(wr_len_q.pop_front());
              w_beat = 0; b_pend++;
            end else w_beat++;
          end
        end
        if (dst_b_valid && dst_b_ready) begin b_pend--; b_idx++; end
      end
      @(negedge clk);
      src_ar_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_addr_q.size() > 0) begin
        src_r_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        src_r_data  = src_mem[(int'(rd_addr_q[0] >> 3) + r_beat) & 63];
        src_r_last  = (r_beat == int'(rd_len_q[0]));
      end else begin
        src_r_valid = 1'b0; src_r_last = 1'b0;
      end
      dst_aw_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      dst_w_ready  = w_stall ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      dst_b_valid  = (b_pend > 0);
      dst_b_resp   = (b_idx == b_err_idx) ? 2'b10 : 2'b00;
    end
  end

  // Present one request for a single cycle; returns at the negedge after accept
  task automatic req(input string tag, input logic [63:0] s, input logic [63:0] d, input logic [63:0] l);
    @(negedge clk);
    r_src = s; r_dest = d; r_len = l; r_valid = 1'b1;
    check_eq({tag, "_ready_idle"}, r_ready, 1'b1);
    @(negedge clk);
    r_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    check_eq({tag, "_done_seen"}, seen, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      src_mem[i] = 64'h1234_5678_0000_0000 + 64'(i) * 64'h0001_0000_0101_0001;
    clear_logs();
    repeat (3) @(negedge clk);
    check_eq("rst_r_ready", r_ready, 1'b1);
    check_eq("rst_valids", {src_ar_valid, dst_aw_valid, dst_w_valid, src_r_ready, dst_b_ready}, 5'd0);
    check_eq("rst_done_err", {done, err}, 2'b00);
    check_eq("rst_perf", perf_beats, 32'd0);
    rst = 1'b0;

    // Single full burst
    clear_logs();
    req("t1", 64'h0, 64'h40, 64'd64);
    check_eq("t1_busy", r_ready, 1'b0);
    wait_done("t1");
    check_eq("t1_err", err, 1'b0);
    check_eq("t1_ready_back", r_ready, 1'b1);
    @(negedge clk);
    check_eq("t1_done_pulse", done, 1'b0);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_ar_n", ar_n, 1);
    check_eq("t1_ar", {ar_log[0], arlen_log[0]}, {64'h0, 8'd7});
    check_eq("t1_aw", {aw_log[0], awlen_log[0]}, {64'h40, 8'd7});
    check_eq("t1_wbeats", w_total, 8);
    check_eq("t1_data", mism(8, 0, 8), 0);
    check_eq("t1_proto", proto_bad + drop_bad, 0);

    // Zero length
    clear_logs();
    req("t3", 64'h8, 64'h10, 64'd0);
    check_eq("t3_done_next", done, 1'b1);
    check_eq("t3_ready", r_ready, 1'b1);
    @(negedge clk);
    check_eq("t3_done_once", done, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("t3_no_bus", ar_n + aw_n, 0);

    // Backpressure, 20 beats -> 8,8,4
    bp = 1'b1;
    clear_logs();
    req("t4", 64'h0, 64'h100, 64'd160);
    wait_done("t4");
    bp = 1'b0;
    check_eq("t4_err", err, 1'b0);
    check_eq("t4_ar_n", ar_n, 3);
    check_eq("t4_ar_addrs", {ar_log[1], ar_log[2]}, {64'd64, 64'd128});
    check_eq("t4_ar_lens", {arlen_log[0], arlen_log[1], arlen_log[2]}, {8'd7, 8'd7, 8'd3});
    check_eq("t4_aw_addrs", {aw_log[0], aw_log[2]}, {64'h100, 64'h180});
    check_eq("t4_aw_len2", awlen_log[2], 8'd3);
    check_eq("t4_data", mism(32, 0, 20), 0);
    check_eq("t4_proto", proto_bad + drop_bad, 0);

    // BRESP error on first of two bursts
    b_err_idx = 0;
    clear_logs();
    req("t5", 64'h80, 64'h0, 64'd128);
    wait_done("t5");
    check_eq("t5_err_set", err, 1'b1);
    check_eq("t5_aw_n", aw_n, 2);
    check_eq("t5_data", mism(0, 16, 16), 0);
    b_err_idx = -1;
    clear_logs();
    req("t5b", 64'h0, 64'h40, 64'd8);
    check_eq("t5_err_clr", err, 1'b0);
    wait_done("t5b");
    check_eq("t5b_err", err, 1'b0);

    // Reset during WR_DATA
    clear_logs();
    w_stall = 1'b1;
    req("t6", 64'h0, 64'h40, 64'd64);
    begin
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        if (dst_w_valid) seen = 1;
        else @(negedge clk);
      end
      check_eq("t6_in_wr_data", seen, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_valids", {src_ar_valid, dst_aw_valid, dst_w_valid, src_r_ready, dst_b_ready}, 5'd0);
    check_eq("t6_ready_err", {r_ready, err, done}, 3'b100);
    rst = 1'b0; w_stall = 1'b0;
    clear_logs();
    req("t6b", 64'h40, 64'h80, 64'd64);
    wait_done("t6b");
    check_eq("t6_data", mism(16, 8, 8), 0);
    check_eq("t6_proto", proto_bad + drop_bad, 0);
`ifdef MOVER_PERF_CNT_EN
    check_eq("t6_perf", perf_beats, 32'(w_total));
`else
    check_eq("t6_perf", perf_beats, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
